traffic_light_monitor: RTL

//  Receiving end of the traffic_light y[1:0] phase bus. Samples y each clock,

---
 rtl/traffic_light_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the y phase bus to lamps and checks order/dwell/stuck/illegal codes; FAULT_FLASH_EN enables red fault flashing
module traffic_light_monitor #(
  parameter int MIN_RED    = 3,
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_DWELL  = 15,
  parameter int DWELL_W    = 5,
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       y,
  input  logic             clr,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             phase_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_stuck,
  output logic             err_illegal,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, SYNC = 2'b11} state_t;
  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] MIN_R = DWELL_W'(MIN_RED);
  localparam logic [DWELL_W-1:0] MIN_G = DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] MIN_Y = DWELL_W'(MIN_YELLOW);
  state_t state_q, state_d, y_s;
  logic [DWELL_W-1:0] dwell_q, dwell_d, min_cur;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [ERR_W-1:0] errc_q, errc_d;
  logic red_q, red_d, yel_q, yel_d, grn_q, grn_d, pd_q, pd_d;
  logic seq_q, seq_d, short_q, short_d, stuck_q, stuck_d, ill_q, ill_d;
  logic illegal, change, same, legal, seq_hit, short_hit, stuck_hit, offend;
  always_comb begin
    y_s       = state_t'(y);
    illegal   = y == 2'b11;
    change    = state_q != SYNC && !illegal && y_s != state_q;
    same      = state_q != SYNC && y_s == state_q;
    legal     = (state_q == RED && y_s == GREEN) || (state_q == GREEN && y_s == YELLOW) ||
                (state_q == YELLOW && y_s == RED);
    min_cur   = state_q == RED ? MIN_R : state_q == GREEN ? MIN_G : MIN_Y;
    seq_hit   = change && !legal;
    short_hit = change && dwell_q < min_cur;
    stuck_hit = same && dwell_q == MAX_D - DWELL_W'(1);
    offend    = seq_hit || short_hit || stuck_hit || illegal;
    state_d   = illegal ? SYNC : state_q == SYNC ? (y_s == RED ? RED : SYNC) : y_s;
    dwell_d   = illegal ? '0 :
                state_q == SYNC ? (y_s == RED ? DWELL_W'(1) : '0) :
                same ? (dwell_q == MAX_D ? dwell_q : dwell_q + DWELL_W'(1)) : DWELL_W'(1);
    pd_d      = change && legal;
    cyc_d     = cyc_q + CNT_W'(change && legal && state_q == YELLOW);
    red_d     = y == 2'b00;
    grn_d     = y == 2'b01;
    yel_d     = y == 2'b10;
    seq_d     = seq_hit || (seq_q && !clr);
    short_d   = short_hit || (short_q && !clr);
    stuck_d   = stuck_hit || (stuck_q && !clr);
    ill_d     = illegal || (ill_q && !clr);
    errc_d    = clr ? ERR_W'(offend) : (offend && errc_q != '1) ? errc_q + ERR_W'(1) : errc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      dwell_q <= '0;
      cyc_q   <= '0;
      errc_q  <= '0;
      red_q   <= 1'b0;
      yel_q   <= 1'b0;
      grn_q   <= 1'b0;
      pd_q    <= 1'b0;
      seq_q   <= 1'b0;
      short_q <= 1'b0;
      stuck_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cyc_q   <= cyc_d;
      errc_q  <= errc_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
      pd_q    <= pd_d;
      seq_q   <= seq_d;
      short_q <= short_d;
      stuck_q <= stuck_d;
      ill_q   <= ill_d;
    end
  end
  assign phase_done  = pd_q;
  assign cycle_count = cyc_q;
  assign err_seq     = seq_q;
  assign err_short   = short_q;
  assign err_stuck   = stuck_q;
  assign err_illegal = ill_q;
  assign err_count   = errc_q;
`ifdef FAULT_FLASH_EN
  logic any_err;
  logic [2:0] flash_q, flash_d;
  always_comb begin
    any_err = seq_q || short_q || stuck_q || ill_q;
    flash_d = any_err ? flash_q + 3'd1 : 3'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flash_q <= 3'd0;
    else flash_q <= flash_d;
  end
  assign lamp_red    = any_err ? ~flash_q[2] : red_q;
  assign lamp_yellow = yel_q && !any_err;
  assign lamp_green  = grn_q && !any_err;
`else
  assign lamp_red    = red_q;
  assign lamp_yellow = yel_q;
  assign lamp_green  = grn_q;
`endif
endmodule
